// File: rtl/hazard_ctrl_mc.sv
// Hazard/control unit for the 5-stage pipeline: load-use stalls, multi-cycle mul/div hold, MEM-stage redirect flushes, perf counters.
// Latency: control outputs are combinational from inputs and registered state; counters update one cycle after the event.
// Backpressure: drives pc/IF_ID write-enables low and holds or bubbles pipeline registers; it never receives backpressure itself.
module hazard_ctrl_mc #(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int MULDIV_LATENCY = 32,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EX_mem_read_i,
    input  logic [REG_ADDR_W-1:0] EX_reg_rt_i,
    input  logic [REG_ADDR_W-1:0] ID_reg_rs_i,
    input  logic [REG_ADDR_W-1:0] ID_reg_rt_i,
    input  logic                  ID_uses_rs_i,
    input  logic                  ID_uses_rt_i,
    input  logic                  EX_muldiv_start_i,
    input  logic                  MEM_jump_i,
    input  logic                  MEM_jr_i,
    input  logic                  MEM_branch_taken_i,
    output logic                  pc_write_o,
    output logic                  IF_ID_write_o,
    output logic                  stall_o,
    output logic                  EX_hold_o,
    output logic                  EX_MEM_bubble_o,
    output logic                  IF_ID_flush_o,
    output logic                  ID_EX_flush_o,
    output logic                  EX_MEM_flush_o,
    output logic                  muldiv_busy_o,
    output logic                  muldiv_done_o,
    output logic                  muldiv_abort_o,
    output logic [CNT_W-1:0]      stall_cycles_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam int LW = $clog2(LOAD_USE_STALL) + 1;
    localparam int MW = $clog2(MULDIV_LATENCY) + 1;
    localparam logic [LW-1:0] LCNT_INIT = LW'(LOAD_USE_STALL - 1);
    // The start cycle (still IDLE) and the DONE cycle each count as one EX
    // cycle, so BUSY lasts MULDIV_LATENCY-2 cycles; mcnt holds the number of
    // BUSY cycles still to go after the current one.
    localparam logic [MW-1:0] MCNT_INIT =
        (MULDIV_LATENCY > 2) ? MW'(MULDIV_LATENCY - 3) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t       state;
    logic [MW-1:0]   mcnt;
    logic [LW-1:0]   lcnt;

    logic redirect, rs_hit, rt_hit, luse_hit, luse_active, md_busy;

    assign redirect    = MEM_jump_i | MEM_jr_i | MEM_branch_taken_i;
    assign rs_hit      = ID_uses_rs_i && (ID_reg_rs_i == EX_reg_rt_i);
    assign rt_hit      = ID_uses_rt_i && (ID_reg_rt_i == EX_reg_rt_i);
    assign luse_hit    = EX_mem_read_i && (EX_reg_rt_i != '0) && (rs_hit || rt_hit);
    assign luse_active = luse_hit || (lcnt != '0);
    assign md_busy     = ((state == IDLE) && EX_muldiv_start_i) || (state == BUSY);

    // Pipeline control outputs, priority redirect > mul/div > load-use
    always_comb begin
        pc_write_o      = 1'b1;
        IF_ID_write_o   = 1'b1;
        stall_o         = 1'b0;
        EX_hold_o       = 1'b0;
        EX_MEM_bubble_o = 1'b0;
        IF_ID_flush_o   = 1'b0;
        ID_EX_flush_o   = 1'b0;
        EX_MEM_flush_o  = 1'b0;
        muldiv_busy_o   = 1'b0;
        muldiv_done_o   = 1'b0;
        muldiv_abort_o  = 1'b0;
        if (!reset) begin
            muldiv_busy_o = (state == BUSY);
            muldiv_done_o = (state == DONE);
            if (redirect) begin
                IF_ID_flush_o  = 1'b1;
                ID_EX_flush_o  = 1'b1;
                EX_MEM_flush_o = 1'b1;
                muldiv_abort_o = (state != IDLE) || EX_muldiv_start_i;
            end else if (md_busy) begin
                pc_write_o      = 1'b0;
                IF_ID_write_o   = 1'b0;
                EX_hold_o       = 1'b1;
                EX_MEM_bubble_o = 1'b1;
            end else if (luse_active) begin
                pc_write_o    = 1'b0;
                IF_ID_write_o = 1'b0;
                stall_o       = 1'b1;
            end
        end
    end

    // Mul/div FSM and load-use bubble counter; a redirect kills both
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mcnt  <= '0;
            lcnt  <= '0;
        end else if (redirect) begin
            state <= IDLE;
            mcnt  <= '0;
            lcnt  <= '0;
        end else begin
            // load-use keeps counting underneath a mul/div hold
            if (luse_hit && (lcnt == '0))
                lcnt <= LCNT_INIT;
            else if (lcnt != '0)
                lcnt <= lcnt - LW'(1);

            case (state)
                IDLE: begin
                    if (EX_muldiv_start_i) begin
                        state <= (MULDIV_LATENCY > 2) ? BUSY : DONE;
                        mcnt  <= MCNT_INIT;
                    end
                end
                BUSY: begin
                    if (mcnt == '0)
                        state <= DONE;
                    else
                        mcnt <= mcnt - MW'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_o <= '0;
            flush_count_o  <= '0;
        end else begin
            if (!pc_write_o && !redirect && (stall_cycles_o != CNT_MAX))
                stall_cycles_o <= stall_cycles_o + CNT_W'(1);
            if (redirect && (flush_count_o != CNT_MAX))
                flush_count_o <= flush_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
module tb_hazard_ctrl_mc;

    localparam int RAW = 5;
    localparam int LUS = 3;
    localparam int LAT = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic reset;
    logic mem_read, uses_rs, uses_rt, md_start, jmp, jr, br;
    logic [RAW-1:0] ex_rt, id_rs, id_rt;
    logic pc_write, if_id_write, stall, ex_hold, ex_mem_bubble;
    logic if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_done, md_abort;
    logic [CW-1:0] stall_cycles, flush_count;

    hazard_ctrl_mc #(
        .REG_ADDR_W(RAW), .LOAD_USE_STALL(LUS), .MULDIV_LATENCY(LAT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .EX_mem_read_i(mem_read), .EX_reg_rt_i(ex_rt),
        .ID_reg_rs_i(id_rs), .ID_reg_rt_i(id_rt),
        .ID_uses_rs_i(uses_rs), .ID_uses_rt_i(uses_rt),
        .EX_muldiv_start_i(md_start),
        .MEM_jump_i(jmp), .MEM_jr_i(jr), .MEM_branch_taken_i(br),
        .pc_write_o(pc_write), .IF_ID_write_o(if_id_write), .stall_o(stall),
        .EX_hold_o(ex_hold), .EX_MEM_bubble_o(ex_mem_bubble),
        .IF_ID_flush_o(if_id_flush), .ID_EX_flush_o(id_ex_flush),
        .EX_MEM_flush_o(ex_mem_flush),
        .muldiv_busy_o(md_busy), .muldiv_done_o(md_done), .muldiv_abort_o(md_abort),
        .stall_cycles_o(stall_cycles), .flush_count_o(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic pc, ifid, stl, hold, bub, f1, f2, f3, busy, done, abrt;
        int   sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: bubbles still owed to a load, position of the
    // current mul/div op within its LAT EX cycles (0 = none), counters.
    int m_luse_left = 0;
    int m_md_pos    = 0;
    int m_sc        = 0;
    int m_fc        = 0;

    task automatic cmp(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("pc_write", int'(pc_write), int'(e.pc));
            cmp("if_id_write", int'(if_id_write), int'(e.ifid));
            cmp("stall", int'(stall), int'(e.stl));
            cmp("ex_hold", int'(ex_hold), int'(e.hold));
            cmp("ex_mem_bubble", int'(ex_mem_bubble), int'(e.bub));
            cmp("if_id_flush", int'(if_id_flush), int'(e.f1));
            cmp("id_ex_flush", int'(id_ex_flush), int'(e.f2));
            cmp("ex_mem_flush", int'(ex_mem_flush), int'(e.f3));
            cmp("muldiv_busy", int'(md_busy), int'(e.busy));
            cmp("muldiv_done", int'(md_done), int'(e.done));
            cmp("muldiv_abort", int'(md_abort), int'(e.abrt));
            if (!e.rst) begin
                cmp("stall_cycles", int'(stall_cycles), e.sc);
                cmp("flush_count", int'(flush_count), e.fc);
            end
        end
    end

    // Drive one cycle of inputs, predict the outputs, advance the model
    task automatic cyc(input logic rst, input logic mr, input int ert,
                       input int rs, input int rt, input logic urs, input logic urt,
                       input logic st, input logic j, input logic r, input logic b);
        exp_t e;
        logic redir, hit, lact, mdb;
        int   pos_now;
        reset = rst; mem_read = mr; ex_rt = RAW'(ert); id_rs = RAW'(rs); id_rt = RAW'(rt);
        uses_rs = urs; uses_rt = urt; md_start = st; jmp = j; jr = r; br = b;

        e = '{rst: rst, pc: 1'b1, ifid: 1'b1, stl: 1'b0, hold: 1'b0, bub: 1'b0,
              f1: 1'b0, f2: 1'b0, f3: 1'b0, busy: 1'b0, done: 1'b0, abrt: 1'b0,
              sc: m_sc, fc: m_fc};
        if (rst) begin
            m_luse_left = 0; m_md_pos = 0; m_sc = 0; m_fc = 0;
        end else begin
            redir   = j | r | b;
            hit     = mr && (ert != 0) && ((urs && rs == ert) || (urt && rt == ert));
            lact    = hit || (m_luse_left > 0);
            pos_now = (m_md_pos != 0) ? m_md_pos : (st ? 1 : 0);
            mdb     = (pos_now >= 1) && (pos_now < LAT);
            e.busy  = (m_md_pos >= 2) && (m_md_pos < LAT);
            e.done  = (m_md_pos == LAT);
            if (redir) begin
                e.f1 = 1'b1; e.f2 = 1'b1; e.f3 = 1'b1;
                e.abrt = (m_md_pos != 0) || st;
            end else if (mdb) begin
                e.pc = 1'b0; e.ifid = 1'b0; e.hold = 1'b1; e.bub = 1'b1;
            end else if (lact) begin
                e.pc = 1'b0; e.ifid = 1'b0; e.stl = 1'b1;
            end
            if (!e.pc && !redir && m_sc < CMAX) m_sc++;
            if (redir && m_fc < CMAX) m_fc++;
            if (redir) m_luse_left = 0;
            else if (hit && m_luse_left == 0) m_luse_left = LUS - 1;
            else if (m_luse_left > 0) m_luse_left--;
            if (redir || pos_now == 0 || pos_now == LAT) m_md_pos = 0;
            else m_md_pos = pos_now + 1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; mem_read = 0; ex_rt = '0; id_rs = '0; id_rt = '0;
        uses_rs = 0; uses_rt = 0; md_start = 0; jmp = 0; jr = 0; br = 0;
        @(posedge clk);
        #1;
        do_reset(3);
        idle(2);
        // single load-use hit on rs -> LUS-cycle stall
        cyc(0, 1, 8, 8, 0, 1, 0, 0, 0, 0, 0);
        idle(4);
        // hit on rt
        cyc(0, 1, 5, 0, 5, 0, 1, 0, 0, 0, 0);
        idle(4);
        // $0 destination and unused rt never stall
        cyc(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 7, 3, 7, 1, 0, 0, 0, 0, 0);
        idle(2);
        // mul/div start pulse, then start held across the whole op
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(4);
        for (int i = 0; i < LAT; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(3);
        // jr in the second BUSY cycle aborts the op
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // redirect and load-use hit together: hit discarded
        cyc(0, 1, 9, 9, 0, 1, 0, 0, 0, 0, 1);
        idle(4);
        // load-use overlapping a mul/div hold
        cyc(0, 1, 4, 4, 0, 1, 0, 1, 0, 0, 0);
        idle(6);
        // 20 consecutive stall cycles saturate the stall counter
        for (int i = 0; i < 20; i++) cyc(0, 1, 6, 6, 6, 1, 1, 0, 0, 0, 0);
        idle(2);
        // reset in the middle of BUSY
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        do_reset(1);
        idle(3);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 249) == 0),
                logic'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 5) == 0),
                logic'($urandom_range(0, 29) == 0),
                logic'($urandom_range(0, 29) == 0),
                logic'($urandom_range(0, 29) == 0));
        end
        idle(2);
        @(negedge clk);
        #1;
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
